// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard AXI peripheral: register offsets,
// AXI response codes, read/write FSM states, STATUS bit positions and debug view.
package ps2_kbd_pkg;

  // Register select taken from addr[4:3]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DATA_VALID_BIT = 8;
  localparam int ST_OVF_BIT     = 16;
  localparam int ST_FERR_BIT    = 17;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_CLEAR_BIT  = 2;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef struct packed {
    r_state_e   rd;
    w_state_e   wr;
    logic [3:0] bit_cnt;
  } ps2_dbg_t;

endpackage

// File: rtl/ps2_kbd_axi_if.sv
// AXI4 slave channel bundle for the PS/2 keyboard peripheral.
// valid/ready: a beat transfers on the rising clock edge where both are high; once raised, valid and its payload hold until that edge.
interface ps2_kbd_axi_if #(
  parameter int ID_W = 4
);
  logic            awready;
  logic            awvalid;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wready;
  logic            wvalid;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;

  logic            bready;
  logic            bvalid;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic            arready;
  logic            arvalid;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rready;
  logic            rvalid;
  logic [1:0]      rresp;
  logic [63:0]     rdata;
  logic            rlast;
  logic [ID_W-1:0] rid;

  modport master (
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_dat, shifts 11-bit frames on
// falling edges, checks start/parity/stop and discards stalled partial frames.
module ps2_rx_frame #(
  parameter int WDOG_CYC = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o,
  output logic [3:0] bit_cnt_o
);
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [2:0]      clk_sync_q;
  logic [1:0]      dat_sync_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      frame_q, frame_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            fall;
  logic [10:0]     full;

  // Idle line is high, so the synchroniser resets to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      wdog_q     <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      wdog_q     <= wdog_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign full = {dat_sync_q[1], frame_q};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    wdog_d    = wdog_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      wdog_d  = '0;
      frame_d = full[10:1];
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        byte_d    = full[8:1];
        // full[0]=start, full[8:1]=data, full[9]=odd parity, full[10]=stop
        if (!full[0] && full[10] && (^full[9:1]))
          valid_d = 1'b1;
        else
          err_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wdog_q == WD_LAST) begin
        bit_cnt_d = '0;
        wdog_d    = '0;
        err_d     = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end else begin
      wdog_d = '0;
    end
  end

  assign byte_o    = byte_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/ps2_kbd_axi.sv
// PS/2 keyboard receiver with scancode FIFO and AXI4 DATA/STATUS/CTRL registers.
// Optional level interrupt and CTRL[0] enable when PS2_KBD_IRQ_EN is defined.
module ps2_kbd_axi
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 4,
  parameter int WDOG_CYC   = 50000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  ps2_kbd_axi_if.slave io_slave,
  output logic         irq,
  output ps2_dbg_t     dbg_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [3:0] rx_bit_cnt;

  ps2_rx_frame #(.WDOG_CYC(WDOG_CYC)) u_rx (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid),
    .err_o     (rx_err),
    .bit_cnt_o (rx_bit_cnt)
  );

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          irq_en_q;
  logic          push, push_ok, pop, full, flush, clr, ctrl_wr;

  r_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [7:0]      rlen_q, rlen_d;
  logic [7:0]      rbeat_q, rbeat_d;
  logic [1:0]      raddr_q, raddr_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            sample;
  logic [1:0]      sel;
  logic [63:0]     status_w, ctrl_w;

  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      waddr_q, waddr_d;
  logic            wfirst_q, wfirst_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      raddr_q   <= REG_DATA;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      waddr_q   <= REG_DATA;
      wfirst_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wfirst_q  <= wfirst_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= rx_byte;
  end

`ifdef PS2_KBD_IRQ_EN
  always_ff @(posedge clock) begin
    if (!resetn)
      irq_en_q <= 1'b0;
    else if (ctrl_wr)
      irq_en_q <= io_slave.wdata[CTRL_IRQ_EN_BIT];
  end
  assign irq = irq_en_q & (count_q != '0);
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  // FIFO: flush beats push; a push while full only lands if a pop frees a slot.
  assign flush   = ctrl_wr & io_slave.wdata[CTRL_FLUSH_BIT];
  assign clr     = ctrl_wr & io_slave.wdata[CTRL_CLEAR_BIT];
  assign full    = (count_q == DEPTH_C);
  assign push    = rx_valid & ~flush;
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = clr ? 1'b0 : ovf_q;
    ferr_d   = clr ? 1'b0 : ferr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    end
    if (push && !push_ok)
      ovf_d = 1'b1;
    if (rx_err)
      ferr_d = 1'b1;
  end

  always_comb begin
    status_w              = '0;
    status_w[8:0]         = 9'(count_q);
    status_w[ST_OVF_BIT]  = ovf_q;
    status_w[ST_FERR_BIT] = ferr_q;
    ctrl_w                  = '0;
    ctrl_w[CTRL_IRQ_EN_BIT] = irq_en_q;
  end

  // Read FSM: the next beat is sampled (and DATA popped) on entry and after each accepted non-last beat.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    sample    = 1'b0;
    sel       = raddr_q;
    pop       = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (io_slave.arvalid) begin
          rid_d     = io_slave.arid;
          rlen_d    = io_slave.arlen;
          rbeat_d   = '0;
          raddr_d   = io_slave.araddr[4:3];
          sel       = io_slave.araddr[4:3];
          sample    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (io_slave.rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            sample  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (sample) begin
      rresp_d = RESP_OKAY;
      rdata_d = '0;
      case (sel)
        REG_DATA: begin
          if (count_q != '0) begin
            rdata_d[7:0]           = mem_q[rd_ptr_q];
            rdata_d[DATA_VALID_BIT] = 1'b1;
            pop                    = 1'b1;
          end
        end
        REG_STATUS: rdata_d = status_w;
        REG_CTRL:   rdata_d = ctrl_w;
        default:    rresp_d = RESP_SLVERR;
      endcase
    end
  end

  // Write FSM: only the first W beat of a burst can touch CTRL.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wfirst_d  = wfirst_q;
    ctrl_wr   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (io_slave.awvalid) begin
          bid_d     = io_slave.awid;
          waddr_d   = io_slave.awaddr[4:3];
          wfirst_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (io_slave.wvalid) begin
          wfirst_d = 1'b0;
          if (wfirst_q && (waddr_q == REG_CTRL) && io_slave.wstrb[0])
            ctrl_wr = 1'b1;
          if (io_slave.wlast)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (io_slave.bready)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign io_slave.awready = (w_state_q == W_IDLE);
  assign io_slave.wready  = (w_state_q == W_DATA);
  assign io_slave.bvalid  = (w_state_q == W_RESP);
  assign io_slave.bresp   = (waddr_q == REG_RSVD) ? RESP_SLVERR : RESP_OKAY;
  assign io_slave.bid     = bid_q;

  assign io_slave.arready = (r_state_q == R_IDLE);
  assign io_slave.rvalid  = (r_state_q == R_DATA);
  assign io_slave.rlast   = (r_state_q == R_DATA) && (rbeat_q == rlen_q);
  assign io_slave.rdata   = rdata_q;
  assign io_slave.rresp   = rresp_q;
  assign io_slave.rid     = rid_q;

  assign dbg_o.rd      = r_state_q;
  assign dbg_o.wr      = w_state_q;
  assign dbg_o.bit_cnt = rx_bit_cnt;

endmodule
